// File: rtl/uart_cmd_ctrl.sv
// Command sequencer between a UART receiver, a register file, an ALU and the TX FIFO.
// Decodes AA/BB/CC/DD command frames and returns read data or ALU results over TX.
module uart_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
    input  logic                      RX_D_VLD,
    output logic                      RF_WrEn,
    output logic                      RF_RdEn,
    output logic [ADDR_WIDTH-1:0]     RF_Address,
    output logic [DATA_WIDTH-1:0]     RF_WrData,
    input  logic [DATA_WIDTH-1:0]     RF_RdData,
    input  logic                      RF_RdData_VLD,
    output logic                      ALU_EN,
    output logic [3:0]                ALU_FUN,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      ALU_OUT_VLD,
    output logic                      CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]     TX_P_DATA,
    output logic                      TX_D_VLD,
    input  logic                      FIFO_FULL
);

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OPA,
        OPB,
        FUN,
        ALU_WAIT,
        TX_RD,
        TX_LSB,
        TX_MSB
    } state_t;

    localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

    state_t state, next_state;

    logic [ADDR_WIDTH-1:0]   wr_addr, wr_addr_d;
    logic [DATA_WIDTH-1:0]   rd_data, rd_data_d;
    logic [2*DATA_WIDTH-1:0] alu_res, alu_res_d;

    logic                    wr_en_d, rd_en_d, alu_en_d, gate_d, tx_vld_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_d, tx_data_d;
    logic [3:0]              fun_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_WR:      next_state = WR_ADDR;
                        CMD_RD:      next_state = RD_ADDR;
                        CMD_ALU_OP:  next_state = OPA;
                        CMD_ALU_NOP: next_state = FUN;
                        default:     next_state = IDLE;
                    endcase
                end
            end
            WR_ADDR:  if (RX_D_VLD)      next_state = WR_DATA;
            WR_DATA:  if (RX_D_VLD)      next_state = IDLE;
            RD_ADDR:  if (RX_D_VLD)      next_state = RD_WAIT;
            RD_WAIT:  if (RF_RdData_VLD) next_state = TX_RD;
            OPA:      if (RX_D_VLD)      next_state = OPB;
            OPB:      if (RX_D_VLD)      next_state = FUN;
            FUN:      if (RX_D_VLD)      next_state = ALU_WAIT;
            ALU_WAIT: if (ALU_OUT_VLD)   next_state = TX_LSB;
            TX_RD:    if (!FIFO_FULL)    next_state = IDLE;
            TX_LSB:   if (!FIFO_FULL)    next_state = TX_MSB;
            TX_MSB:   if (!FIFO_FULL)    next_state = IDLE;
            default:                     next_state = IDLE;
        endcase
    end

    // Next values for the registered outputs and captured data; strobes default low,
    // buses and the clock-gate enable hold their last value.
    always_comb begin
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        tx_vld_d  = 1'b0;
        addr_d    = RF_Address;
        wr_data_d = RF_WrData;
        fun_d     = ALU_FUN;
        gate_d    = CLK_GATE_EN;
        tx_data_d = TX_P_DATA;
        wr_addr_d = wr_addr;
        rd_data_d = rd_data;
        alu_res_d = alu_res;
        case (state)
            WR_ADDR: begin
                if (RX_D_VLD) wr_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_en_d   = 1'b1;
                    addr_d    = wr_addr;
                    wr_data_d = RX_P_DATA;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    rd_en_d = 1'b1;
                    addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                end
            end
            RD_WAIT: begin
                if (RF_RdData_VLD) rd_data_d = RF_RdData;
            end
            OPA: begin
                if (RX_D_VLD) begin
                    wr_en_d   = 1'b1;
                    addr_d    = '0;
                    wr_data_d = RX_P_DATA;
                end
            end
            OPB: begin
                if (RX_D_VLD) begin
                    wr_en_d   = 1'b1;
                    addr_d    = ADDR_WIDTH'(1);
                    wr_data_d = RX_P_DATA;
                end
            end
            FUN: begin
                if (RX_D_VLD) begin
                    alu_en_d = 1'b1;
                    fun_d    = RX_P_DATA[3:0];
                    gate_d   = 1'b1;
                end
            end
            ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    alu_res_d = ALU_OUT;
                    gate_d    = 1'b0;
                end
            end
            TX_RD: begin
                if (!FIFO_FULL) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = rd_data;
                end
            end
            TX_LSB: begin
                if (!FIFO_FULL) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = alu_res[DATA_WIDTH-1:0];
                end
            end
            TX_MSB: begin
                if (!FIFO_FULL) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = alu_res[2*DATA_WIDTH-1:DATA_WIDTH];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RF_WrEn     <= 1'b0;
            RF_RdEn     <= 1'b0;
            RF_Address  <= '0;
            RF_WrData   <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
            wr_addr     <= '0;
            rd_data     <= '0;
            alu_res     <= '0;
        end else begin
            RF_WrEn     <= wr_en_d;
            RF_RdEn     <= rd_en_d;
            RF_Address  <= addr_d;
            RF_WrData   <= wr_data_d;
            ALU_EN      <= alu_en_d;
            ALU_FUN     <= fun_d;
            CLK_GATE_EN <= gate_d;
            TX_P_DATA   <= tx_data_d;
            TX_D_VLD    <= tx_vld_d;
            wr_addr     <= wr_addr_d;
            rd_data     <= rd_data_d;
            alu_res     <= alu_res_d;
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed frames plus random command traffic,
// with every output strobe logged and compared against per-transaction expectations.
module tb_uart_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic        RF_WrEn, RF_RdEn;
    logic [3:0]  RF_Address;
    logic [7:0]  RF_WrData;
    logic [7:0]  RF_RdData;
    logic        RF_RdData_VLD;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic        CLK_GATE_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        FIFO_FULL;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int gate_cnt = 0;
    int exp_gate = 0;

    logic [31:0] act_wr[$], exp_wr[$];
    logic [31:0] act_rd[$], exp_rd[$];
    logic [31:0] act_alu[$], exp_alu[$];
    logic [31:0] act_tx[$], exp_tx[$];

    uart_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
        .RF_WrData(RF_WrData), .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .CLK_GATE_EN(CLK_GATE_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .FIFO_FULL(FIFO_FULL)
    );

    always #5 CLK = ~CLK;

    // Log every strobe seen between edges; a strobe wider than one cycle shows up as an extra event.
    always @(negedge CLK) begin
        if (RF_WrEn)     act_wr.push_back({20'h0, RF_Address, RF_WrData});
        if (RF_RdEn)     act_rd.push_back({28'h0, RF_Address});
        if (ALU_EN)      act_alu.push_back({28'h0, ALU_FUN});
        if (TX_D_VLD)    act_tx.push_back({24'h0, TX_P_DATA});
        if (CLK_GATE_EN) gate_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        cyc++;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        tick();
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
    endtask

    function automatic logic [31:0] out_bus();
        return {3'b0, RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
                CLK_GATE_EN, TX_P_DATA, TX_D_VLD};
    endfunction

    function automatic logic [7:0] cmd_byte(input int k);
        case (k)
            0:       return 8'hAA;
            1:       return 8'hBB;
            2:       return 8'hCC;
            default: return 8'hDD;
        endcase
    endfunction

    task automatic compare_queue(input string tag, input logic [31:0] act[$], input logic [31:0] exp[$]);
        checkOutput({tag, "_count"}, act.size(), exp.size());
        for (int i = 0; i < act.size() && i < exp.size(); i++)
            checkOutput($sformatf("%s[%0d]", tag, i), act[i], exp[i]);
    endtask

    task automatic check_queues(input string tag);
        repeat (4) tick();
        compare_queue({tag, "_rfwr"}, act_wr, exp_wr);
        compare_queue({tag, "_rfrd"}, act_rd, exp_rd);
        compare_queue({tag, "_alu"}, act_alu, exp_alu);
        compare_queue({tag, "_tx"}, act_tx, exp_tx);
        checkOutput({tag, "_gate_cycles"}, gate_cnt, exp_gate);
        act_wr.delete(); exp_wr.delete();
        act_rd.delete(); exp_rd.delete();
        act_alu.delete(); exp_alu.delete();
        act_tx.delete(); exp_tx.delete();
        gate_cnt = 0;
        exp_gate = 0;
    endtask

    // Idle a few cycles, sometimes sending a command byte that must be dropped.
    task automatic wait_with_drops();
        int w = $urandom_range(0, 3);
        repeat (w) tick();
        if ($urandom_range(0, 1) == 1) applyStimulus(cmd_byte($urandom_range(0, 3)));
    endtask

    // Holds FIFO_FULL for 'stall' cycles after the result strobe, optionally dropping a byte meanwhile.
    task automatic hold_fifo(input int stall);
        if (stall == 3) begin
            applyStimulus(cmd_byte($urandom_range(0, 3)));
            tick();
        end else begin
            repeat (stall) tick();
        end
        FIFO_FULL = 1'b0;
    endtask

    task automatic respond_rd(input logic [7:0] d, input bit drops);
        int stall = drops ? $urandom_range(0, 3) : 0;
        if (drops) wait_with_drops(); else tick();
        RF_RdData     = d;
        RF_RdData_VLD = 1'b1;
        FIFO_FULL     = (stall != 0);
        tick();
        RF_RdData_VLD = 1'b0;
        hold_fifo(stall);
        exp_tx.push_back({24'h0, d});
    endtask

    task automatic respond_alu(input int c1, input logic [15:0] r, input bit drops);
        int stall = drops ? $urandom_range(0, 3) : 0;
        if (drops) wait_with_drops();
        exp_gate += cyc - c1 + 1;
        ALU_OUT     = r;
        ALU_OUT_VLD = 1'b1;
        FIFO_FULL   = (stall != 0);
        tick();
        ALU_OUT_VLD = 1'b0;
        hold_fifo(stall);
        exp_tx.push_back({24'h0, 8'(r % 256)});
        exp_tx.push_back({24'h0, 8'(r / 256)});
    endtask

    initial begin
        logic [7:0]  a, d, opb, f;
        logic [15:0] r;
        int          c1;

        RST = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0; RF_RdData = '0; RF_RdData_VLD = 1'b0;
        ALU_OUT = '0; ALU_OUT_VLD = 1'b0; FIFO_FULL = 1'b0;
        repeat (3) tick();
        checkOutput("reset_outputs", out_bus(), 32'h0);
        RST = 1'b1;
        tick();
        checkOutput("post_reset_outputs", out_bus(), 32'h0);

        // Register write frame
        applyStimulus(8'hAA); applyStimulus(8'h05); applyStimulus(8'h3C);
        exp_wr.push_back({20'h0, 4'h5, 8'h3C});
        check_queues("wr_frame");

        // Register read frame returning one TX byte
        applyStimulus(8'hBB); applyStimulus(8'h07);
        exp_rd.push_back(32'h7);
        respond_rd(8'h5A, 1'b0);
        check_queues("rd_frame");

        // ALU with operands: operands land at RF 0 and 1, result goes out LSB first
        applyStimulus(8'hCC); applyStimulus(8'h10); applyStimulus(8'h20); applyStimulus(8'h00);
        c1 = cyc;
        exp_wr.push_back({20'h0, 4'h0, 8'h10});
        exp_wr.push_back({20'h0, 4'h1, 8'h20});
        exp_alu.push_back(32'h0);
        tick();
        checkOutput("gate_high_in_alu_wait", {31'h0, CLK_GATE_EN}, 32'h1);
        respond_alu(c1, 16'h0030, 1'b0);
        check_queues("alu_cc_frame");

        // ALU without operands, TX held off by a full FIFO for 5 cycles
        applyStimulus(8'hDD); applyStimulus(8'h02);
        c1 = cyc;
        exp_alu.push_back(32'h2);
        tick(); tick();
        exp_gate += cyc - c1 + 1;
        ALU_OUT = 16'hBEEF; ALU_OUT_VLD = 1'b1; FIFO_FULL = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0;
        repeat (4) tick();
        checkOutput("no_push_while_full", act_tx.size(), 32'h0);
        FIFO_FULL = 1'b0;
        exp_tx.push_back(32'hEF);
        exp_tx.push_back(32'hBE);
        check_queues("fifo_full_frame");

        // Unknown command byte and stray valids in IDLE do nothing
        applyStimulus(8'h55);
        tick(); RF_RdData_VLD = 1'b1; ALU_OUT_VLD = 1'b1; tick(); RF_RdData_VLD = 1'b0; ALU_OUT_VLD = 1'b0;
        check_queues("idle_junk");

        // Reset in the middle of a write frame abandons it
        applyStimulus(8'hAA); applyStimulus(8'h05);
        tick();
        #2 RST = 1'b0;
        #1 checkOutput("async_reset_outputs", out_bus(), 32'h0);
        tick();
        RST = 1'b1;
        applyStimulus(8'h3C);
        check_queues("after_reset_no_write");
        applyStimulus(8'hAA); applyStimulus(8'h03); applyStimulus(8'h44);
        exp_wr.push_back({20'h0, 4'h3, 8'h44});
        check_queues("after_reset_new_cmd");

        // Random command traffic against the expected event streams
        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom); d = 8'($urandom); opb = 8'($urandom); f = 8'($urandom);
            r = 16'($urandom);
            case ($urandom_range(0, 4))
                0: begin
                    applyStimulus(8'hAA); applyStimulus(a); applyStimulus(d);
                    exp_wr.push_back({20'h0, 4'(a % 16), d});
                end
                1: begin
                    applyStimulus(8'hBB); applyStimulus(a);
                    exp_rd.push_back(32'(a % 16));
                    respond_rd(d, 1'b1);
                end
                2: begin
                    applyStimulus(8'hCC); applyStimulus(a); applyStimulus(opb); applyStimulus(f);
                    c1 = cyc;
                    exp_wr.push_back({20'h0, 4'h0, a});
                    exp_wr.push_back({20'h0, 4'h1, opb});
                    exp_alu.push_back(32'(f % 16));
                    respond_alu(c1, r, 1'b1);
                end
                3: begin
                    applyStimulus(8'hDD); applyStimulus(f);
                    c1 = cyc;
                    exp_alu.push_back(32'(f % 16));
                    respond_alu(c1, r, 1'b1);
                end
                default: begin
                    if (a == 8'hAA || a == 8'hBB || a == 8'hCC || a == 8'hDD) a = 8'h5F;
                    applyStimulus(a);
                end
            endcase
            check_queues($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the byte width of UART, register-file and FIFO data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, giving the register-file address width.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock.
REQ-004 SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port RX_P_DATA, input, DATA_WIDTH bits: received UART byte.
REQ-006 SHALL have port RX_D_VLD, input, 1 bit: one-cycle strobe marking RX_P_DATA valid, already synchronized to CLK.
REQ-007 SHALL have ports RF_WrEn and RF_RdEn, outputs, 1 bit each: register-file write and read strobes.
REQ-008 SHALL have ports RF_Address (output, ADDR_WIDTH), RF_WrData (output, DATA_WIDTH), RF_RdData (input, DATA_WIDTH) and RF_RdData_VLD (input, 1).
REQ-009 SHALL have ports ALU_EN (output, 1), ALU_FUN (output, 4), ALU_OUT (input, 2*DATA_WIDTH) and ALU_OUT_VLD (input, 1).
REQ-010 SHALL have port CLK_GATE_EN, output, 1 bit: enables the ALU clock gate.
REQ-011 SHALL have ports TX_P_DATA (output, DATA_WIDTH), TX_D_VLD (output, 1) and FIFO_FULL (input, 1), forming the TX FIFO write side.

Function
REQ-012 SHALL decode command bytes in IDLE: 0xAA = reg write, 0xBB = reg read, 0xCC = ALU op with operands, 0xDD = ALU op without operands.
REQ-013 SHALL ignore any other command byte, staying in IDLE with no output activity.
REQ-014 SHALL implement the states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_RD, TX_LSB and TX_MSB.
REQ-015 SHALL register all outputs; every strobe SHALL be high for exactly one cycle, the cycle after the triggering byte or valid is accepted.
REQ-016 SHALL, for 0xAA: latch RX_P_DATA[ADDR_WIDTH-1:0] in WR_ADDR, then on the data byte pulse RF_WrEn with the latched address and data, and return to IDLE.
REQ-017 SHALL, for 0xBB: on the address byte pulse RF_RdEn with that address, enter RD_WAIT, capture RF_RdData when RF_RdData_VLD is high, and enter TX_RD.
REQ-018 SHALL, for 0xCC: write the OPA byte to RF address 0, write the OPB byte to RF address 1, then enter FUN.
REQ-019 SHALL, for 0xDD: go directly to FUN.
REQ-020 SHALL, in FUN on the function byte: pulse ALU_EN with ALU_FUN = RX_P_DATA[3:0], then enter ALU_WAIT.
REQ-021 SHALL, in ALU_WAIT, capture the 16-bit ALU_OUT when ALU_OUT_VLD is high.
REQ-022 SHALL drive CLK_GATE_EN high from acceptance of the function byte until the cycle ALU_OUT_VLD is seen, inclusive; it SHALL be low otherwise.
REQ-023 SHALL, in TX_RD, TX_LSB and TX_MSB, push one byte per state (TX_D_VLD pulse with TX_P_DATA) only when FIFO_FULL=0, and otherwise hold the state.
REQ-024 SHALL send the read byte from TX_RD, ALU_OUT[7:0] from TX_LSB, then ALU_OUT[15:8] from TX_MSB, and return to IDLE after the final push.
REQ-025 SHALL drop RX_D_VLD bytes that arrive in RD_WAIT, ALU_WAIT or any TX state; dropped bytes SHALL not be reinterpreted as commands.
REQ-026 SHALL ignore RF_RdData_VLD outside RD_WAIT and ALU_OUT_VLD outside ALU_WAIT.
REQ-027 SHALL ignore address-byte bits above ADDR_WIDTH-1.
REQ-028 SHALL wait indefinitely in the wait states; no timeout is provided.

Reset
REQ-029 SHALL, on RST low, immediately and asynchronously return to IDLE and clear all outputs and captured data to 0, including RF_Address, ALU_FUN, TX_P_DATA and CLK_GATE_EN.
REQ-030 SHALL abandon any command in progress on reset, leaving no partial strobe; after RST rises, the first accepted byte SHALL be treated as a command.

Verification
REQ-031 SHALL pass this bench case: bytes AA,05,3C -> one RF_WrEn pulse with RF_Address=5 and RF_WrData=0x3C, then IDLE.
REQ-032 SHALL pass this bench case: bytes BB,07 -> RF_RdEn pulse with address 7; RF_RdData=0x5A with VLD -> a single TX_D_VLD pulse with TX_P_DATA=0x5A.
REQ-033 SHALL pass this bench case: bytes CC,10,20,00 -> RF writes addr0=0x10 and addr1=0x20, ALU_EN pulse with ALU_FUN=0 and CLK_GATE_EN high; ALU_OUT=0x0030 with VLD -> TX pushes 0x30 then 0x00.
REQ-034 SHALL pass this bench case: 0xDD,02 flow with FIFO_FULL held high for 5 cycles before TX_LSB -> no TX_D_VLD while full; bytes then pushed in order after FIFO_FULL falls.
REQ-035 SHALL pass this bench case: byte 0x55 in IDLE -> no output activity; RST low after AA,05 -> outputs 0 and IDLE; then 0x3C alone -> no write.
